// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
// Default geometry is 32 registers of 32 bits; register 0 is the zero register.
package rf_pkg;

    localparam int RF_DATA_W    = 32;
    localparam int RF_ADDR_W    = 5;
    localparam int RF_ZERO_ADDR = 0;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: optional same-cycle write bypass, zero mask.
// Bypass is compiled in when RF_BYPASS_EN is defined.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] memData,
    input  logic              memBusy,
`ifdef RF_BYPASS_EN
    input  logic              waEn,
    input  logic [ADDR_W-1:0] waAddr,
    input  logic [DATA_W-1:0] waData,
    input  logic              wbEn,
    input  logic [ADDR_W-1:0] wbAddr,
    input  logic [DATA_W-1:0] wbData,
    input  logic              issEn,
    input  logic [ADDR_W-1:0] issAddr,
`endif
    output logic [DATA_W-1:0] rdData,
    output logic              rdBusy
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(RF_ZERO_ADDR);

    logic isZero;

    assign isZero = (ZERO_REG != 0) && (rdAddr == ZERO_A);

    // Select stored or in-flight write data, then force the zero register.
    always_comb begin
        rdData = memData;
        rdBusy = memBusy;
`ifdef RF_BYPASS_EN
        if (wbEn && (wbAddr == rdAddr)) begin
            rdData = wbData;
            rdBusy = issEn && (issAddr == rdAddr);
        end else if (waEn && (waAddr == rdAddr)) begin
            rdData = waData;
            rdBusy = issEn && (issAddr == rdAddr);
        end
`endif
        if (isZero) begin
            rdData = '0;
            rdBusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(RF_ZERO_ADDR);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              waLive;
    logic              wbLive;
    logic              issLive;
    logic              waKeep;

    // Qualify requests: drop them in reset and when aimed at the zero register.
    always_comb begin
        waLive  = wa_en && !rst
                  && !((ZERO_REG != 0) && (wa_addr == ZERO_A));
        wbLive  = wb_en && !rst
                  && !((ZERO_REG != 0) && (wb_addr == ZERO_A));
        issLive = iss_en && !rst
                  && !((ZERO_REG != 0) && (iss_addr == ZERO_A));
        waKeep  = waLive && !(wbLive && (wb_addr == wa_addr));
    end

    // Commit writes; port B (load) wins a same-address conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (waKeep) begin
                mem[wa_addr] <= wa_data;
            end
            if (wbLive) begin
                mem[wb_addr] <= wb_data;
            end
        end
    end

    // Scoreboard: writeback clears, issue sets; a new producer beats writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (waLive) begin
                busy[wa_addr] <= 1'b0;
            end
            if (wbLive) begin
                busy[wb_addr] <= 1'b0;
            end
            if (issLive) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRd
        logic [ADDR_W-1:0] addr;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) uPort (
            .rdAddr  (addr),
            .memData (mem[addr]),
            .memBusy (busy[addr]),
`ifdef RF_BYPASS_EN
            .waEn    (waKeep),
            .waAddr  (wa_addr),
            .waData  (wa_data),
            .wbEn    (wbLive),
            .wbAddr  (wb_addr),
            .wbData  (wb_data),
            .issEn   (issLive),
            .issAddr (iss_addr),
`endif
            .rdData  (rd_data[k*DATA_W +: DATA_W]),
            .rdBusy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with four read ports.
// Random traffic is checked every cycle against an array-based model.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int DEPTH = 32;

    logic              clk;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              wa_en;
    logic [AW-1:0]     wa_addr;
    logic [DW-1:0]     wa_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mMem [DEPTH];
    logic          mBusy [DEPTH];

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wa_data  (wa_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: what each register and busy bit must hold.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mMem[i]  <= '0;
                mBusy[i] <= 1'b0;
            end
        end else begin
            if (wa_en && wa_addr != 0 && !(wb_en && wb_addr == wa_addr))
                mMem[wa_addr] <= wa_data;
            if (wb_en && wb_addr != 0)
                mMem[wb_addr] <= wb_data;
            for (int i = 1; i < DEPTH; i++) begin
                if (iss_en && iss_addr == AW'(i))
                    mBusy[i] <= 1'b1;
                else if ((wa_en && wa_addr == AW'(i)) ||
                         (wb_en && wb_addr == AW'(i)))
                    mBusy[i] <= 1'b0;
            end
        end
    end

    function automatic void expRead(input logic [AW-1:0] a,
                                    output logic [DW-1:0] d,
                                    output logic b);
        d = mMem[a];
        b = mBusy[a];
`ifdef RF_BYPASS_EN
        if (wb_en && wb_addr == a) begin
            d = wb_data;
            b = iss_en && iss_addr == a;
        end else if (wa_en && wa_addr == a) begin
            d = wa_data;
            b = iss_en && iss_addr == a;
        end
`endif
        if (rst || a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endfunction

    // Every port compared against the model on every falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] ed;
            logic          eb;
            a = rd_addr[k*AW +: AW];
            expRead(a, ed, eb);
            tests++;
            if (rd_data[k*DW +: DW] !== ed || rd_busy[k] !== eb) begin
                fails++;
                $display("FAIL port%0d addr=%0d t=%0t: got data=%h busy=%b, want data=%h busy=%b",
                         k, a, $time, rd_data[k*DW +: DW], rd_busy[k], ed, eb);
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wa_en  = 1'b0;
        wb_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setRd(input int a0, input int a1, input int a2, input int a3);
        rd_addr[0*AW +: AW] = AW'(a0);
        rd_addr[1*AW +: AW] = AW'(a1);
        rd_addr[2*AW +: AW] = AW'(a2);
        rd_addr[3*AW +: AW] = AW'(a3);
    endtask

    task automatic doWa(input int a, input logic [DW-1:0] d);
        wa_en = 1'b1; wa_addr = AW'(a); wa_data = d;
    endtask

    task automatic doWb(input int a, input logic [DW-1:0] d);
        wb_en = 1'b1; wb_addr = AW'(a); wb_data = d;
    endtask

    task automatic doIss(input int a);
        iss_en = 1'b1; iss_addr = AW'(a);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        wa_addr = '0; wa_data = '0;
        wb_addr = '0; wb_data = '0;
        iss_addr = '0;
        setRd(5, 7, 3, 9);
        #2;
        chk("reset_data", rd_data[31:0], 32'h0);
        chk("reset_busy", {28'h0, rd_busy}, 32'h0);
        #20 rst = 1'b0;
        #1;
        chk("post_release_data", rd_data[63:32], 32'h0);

        // Reset mid-operation
        step();
        doWa(5, 32'hDEADBEEF);
        step();
        idle();
        setRd(5, 5, 0, 1);
        #1;
        chk("r5_written", rd_data[31:0], 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", rd_data[31:0], 32'h0);
        chk("async_rst_busy", {31'h0, rd_busy[0]}, 32'h0);
        #2 rst = 1'b0;

        // Dual-write conflict
        step();
        doWa(7, 32'h11111111);
        doWb(7, 32'h22222222);
        step();
        idle();
        setRd(7, 7, 7, 7);
        #1;
        chk("b_wins", rd_data[31:0], 32'h22222222);

        // Zero register
        step();
        doWa(0, 32'hFFFFFFFF);
        doIss(0);
        setRd(0, 0, 7, 0);
        #1;
        chk("zero_same_cycle", rd_data[31:0], 32'h0);
        step();
        idle();
        #1;
        chk("zero_data", rd_data[31:0], 32'h0);
        chk("zero_busy", {31'h0, rd_busy[0]}, 32'h0);

        // Scoreboard
        step();
        doIss(3);
        setRd(3, 0, 7, 5);
        step();
        idle();
        #1;
        chk("busy_after_issue", {31'h0, rd_busy[0]}, 32'h1);
        step();
        step();
        doWa(3, 32'h5);
        doIss(3);
        step();
        idle();
        #1;
        chk("busy_reissue", {31'h0, rd_busy[0]}, 32'h1);
        chk("r3_after_write", rd_data[31:0], 32'h5);
        step();
        doWb(3, 32'h6);
        step();
        idle();
        #1;
        chk("busy_cleared", {31'h0, rd_busy[0]}, 32'h0);
        chk("r3_second_write", rd_data[31:0], 32'h6);

        // Bypass
        step();
        doWa(9, 32'h1234);
        step();
        idle();
        doWb(9, 32'hCAFE);
        setRd(9, 9, 3, 7);
        #1;
`ifdef RF_BYPASS_EN
        chk("bypass_same_cycle", rd_data[31:0], 32'hCAFE);
`else
        chk("no_bypass_old", rd_data[31:0], 32'h1234);
`endif
        step();
        idle();
        #1;
        chk("bypass_next_cycle", rd_data[31:0], 32'hCAFE);

        // Four ports: distinct then identical addresses
        step();
        setRd(3, 7, 9, 0);
        step();
        chk("port1_r7", rd_data[63:32], 32'h22222222);
        chk("port2_r9", rd_data[95:64], 32'hCAFE);
        setRd(9, 9, 9, 9);
        step();
        chk("port3_same", rd_data[127:96], 32'hCAFE);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            idle();
            wa_en = ($urandom_range(0, 2) != 0);
            wb_en = ($urandom_range(0, 2) != 0);
            iss_en = ($urandom_range(0, 2) != 0);
            wa_addr = AW'($urandom_range(0, (n % 2 == 0) ? 7 : 31));
            wb_addr = AW'($urandom_range(0, (n % 2 == 0) ? 7 : 31));
            iss_addr = AW'($urandom_range(0, (n % 2 == 0) ? 7 : 31));
            wa_data = $urandom;
            wb_data = $urandom;
            for (int k = 0; k < NR; k++) begin
                rd_addr[k*AW +: AW] = (n % 5 == 0) ? rd_addr[0 +: AW]
                                    : AW'($urandom_range(0, (n % 2 == 0) ? 7 : 31));
            end
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b1;
                #5 rst = 1'b0;
            end
        end

        step();
        idle();
        #10;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
